// File: rtl/lathe_seq_pkg.sv
// Shared encodings for the lathe cycle sequencer: state codes, output-bundle
// bit positions and the per-state actuator mapping.
package lathe_seq_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SPINUP = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_MANUAL = 3'd3;
    localparam logic [2:0] ST_COAST  = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_SPINUP = ST_SPINUP,
        S_RUN    = ST_RUN,
        S_MANUAL = ST_MANUAL,
        S_COAST  = ST_COAST,
        S_FAULT  = ST_FAULT
    } state_t;

    localparam int OB_SPINDLE = 0;
    localparam int OB_FEED    = 1;
    localparam int OB_COOLANT = 2;
    localparam int OB_BUSY    = 3;
    localparam int OB_FAULT   = 4;
    localparam int OB_DONE    = 5;
    localparam int OB_W       = 6;

    // Steady-state actuator bundle for a state; the done pulse is added by the caller.
    function automatic logic [OB_W-1:0] state_outputs(input state_t s, input logic jog);
        logic [OB_W-1:0] o;
        o = '0;
        case (s)
            S_SPINUP: begin
                o[OB_SPINDLE] = 1'b1;
                o[OB_COOLANT] = 1'b1;
            end
            S_RUN: begin
                o[OB_SPINDLE] = 1'b1;
                o[OB_COOLANT] = 1'b1;
                o[OB_FEED]    = 1'b1;
            end
            S_MANUAL: begin
                o[OB_SPINDLE] = 1'b1;
                o[OB_COOLANT] = 1'b1;
                o[OB_FEED]    = jog;
            end
            S_COAST: o[OB_COOLANT] = 1'b1;
            S_FAULT: o[OB_FAULT]   = 1'b1;
            default: o = '0;
        endcase
        o[OB_BUSY] = (s != S_IDLE);
        return o;
    endfunction

endpackage

// File: rtl/lathe_cycle_sequencer_timer.sv
// Loadable down-counter that times the SPINUP, RUN and COAST dwells.
module seq_timer
    import lathe_seq_pkg::*;
#(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          expired
);

    logic [TW-1:0] count_reg;

    // Holds at zero once expired so a stalled state never wraps around.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expired = (count_reg == '0);

endmodule

// File: rtl/lathe_cycle_sequencer.sv
// Lathe cycle sequencer: one state machine owning spindle, feed and coolant,
// with AUTO timed cycle, MAN jog cycle, stop/estop arbitration.
module lathe_cycle_sequencer
    import lathe_seq_pkg::*;
#(
    parameter int SPINUP_CYCLES = 16,
    parameter int RUN_CYCLES    = 64,
    parameter int COAST_CYCLES  = 16,
    parameter int TW            = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       estop,
    input  logic       auto_mode,
    input  logic       man_mode,
    input  logic       jog,
    output logic       spindle_on,
    output logic       feed_on,
    output logic       coolant_on,
    output logic       busy,
    output logic       fault,
    output logic       cycle_done,
    output logic [2:0] state_o
);

    localparam logic [TW-1:0] SPINUP_LOAD = TW'(SPINUP_CYCLES - 1);
    localparam logic [TW-1:0] RUN_LOAD    = TW'(RUN_CYCLES - 1);
    localparam logic [TW-1:0] COAST_LOAD  = TW'(COAST_CYCLES - 1);

    state_t          state_reg, state_next;
    logic            start_prev_reg;
    logic            completed_reg, completed_next;
    logic [OB_W-1:0] out_reg, out_next;
    logic            done_next;
    logic            start_edge, auto_only, man_only;
    logic            tmr_load, tmr_expired;
    logic [TW-1:0]   tmr_load_val;

    seq_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .expired  (tmr_expired)
    );

    always_comb begin
        start_edge     = start & ~start_prev_reg;
        auto_only      = auto_mode & ~man_mode;
        man_only       = man_mode & ~auto_mode;
        state_next     = state_reg;
        completed_next = completed_reg;
        done_next      = 1'b0;

        if (estop) begin
            state_next = S_FAULT;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (!stop && start_edge) begin
                        if (auto_only)     state_next = S_SPINUP;
                        else if (man_only) state_next = S_MANUAL;
                    end
                end
                // Leaving AUTO while timed is treated like a stop, never a restart.
                S_SPINUP: begin
                    if (stop || !auto_only) state_next = S_COAST;
                    else if (tmr_expired)   state_next = S_RUN;
                end
                S_RUN: begin
                    if (stop || !auto_only) begin
                        state_next = S_COAST;
                    end else if (tmr_expired) begin
                        state_next     = S_COAST;
                        completed_next = 1'b1;
                    end
                end
                S_MANUAL: begin
                    if (stop || !man_only) state_next = S_COAST;
                end
                S_COAST: begin
                    if (tmr_expired) begin
                        state_next = S_IDLE;
                        done_next  = completed_reg;
                    end
                end
                S_FAULT: begin
                    if (stop) state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end

        if (state_next == S_IDLE) completed_next = 1'b0;

        tmr_load = (state_next != state_reg);
        case (state_next)
            S_SPINUP: tmr_load_val = SPINUP_LOAD;
            S_RUN:    tmr_load_val = RUN_LOAD;
            S_COAST:  tmr_load_val = COAST_LOAD;
            default:  tmr_load_val = '0;
        endcase

        out_next          = state_outputs(state_next, jog);
        out_next[OB_DONE] = done_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            start_prev_reg <= 1'b0;
            completed_reg  <= 1'b0;
            out_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            start_prev_reg <= start;
            completed_reg  <= completed_next;
            out_reg        <= out_next;
        end
    end

    assign spindle_on = out_reg[OB_SPINDLE];
    assign feed_on    = out_reg[OB_FEED];
    assign coolant_on = out_reg[OB_COOLANT];
    assign busy       = out_reg[OB_BUSY];
    assign fault      = out_reg[OB_FAULT];
    assign cycle_done = out_reg[OB_DONE];
    assign state_o    = state_reg;

endmodule

// File: tb/tb_lathe_cycle_sequencer.sv
// Scoreboard bench for lathe_cycle_sequencer: directed scenarios plus random
// operator activity, checked cycle by cycle against a behavioural model.
module tb_lathe_cycle_sequencer;

    localparam int S = 4;
    localparam int R = 8;
    localparam int C = 3;

    localparam int P_IDLE   = 0;
    localparam int P_SPINUP = 1;
    localparam int P_RUN    = 2;
    localparam int P_MANUAL = 3;
    localparam int P_COAST  = 4;
    localparam int P_FAULT  = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, stop = 1'b0, estop = 1'b0;
    logic auto_mode = 1'b0, man_mode = 1'b0, jog = 1'b0;
    logic spindle_on, feed_on, coolant_on, busy, fault, cycle_done;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    lathe_cycle_sequencer #(
        .SPINUP_CYCLES (S),
        .RUN_CYCLES    (R),
        .COAST_CYCLES  (C),
        .TW            (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .estop      (estop),
        .auto_mode  (auto_mode),
        .man_mode   (man_mode),
        .jog        (jog),
        .spindle_on (spindle_on),
        .feed_on    (feed_on),
        .coolant_on (coolant_on),
        .busy       (busy),
        .fault      (fault),
        .cycle_done (cycle_done),
        .state_o    (state_o)
    );

    typedef logic [8:0] vec_t;
    vec_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model: current phase, cycles left in it, and whether RUN finished.
    int m_ph = P_IDLE;
    int m_left = 0;
    bit m_flag = 0;
    bit m_prev_start = 0;

    function automatic int dur(input int ph);
        case (ph)
            P_SPINUP: return S;
            P_RUN:    return R;
            P_COAST:  return C;
            default:  return 0;
        endcase
    endfunction

    function automatic void model_reset();
        m_ph = P_IDLE;
        m_left = 0;
        m_flag = 0;
        m_prev_start = 0;
    endfunction

    function automatic vec_t model_step(input bit st, input bit sp, input bit es,
                                        input bit au, input bit mn, input bit jg);
        bit edge_s, want_auto, want_man, dn, sp_o, fd_o, cl_o;
        int nx;
        edge_s = st && !m_prev_start;
        m_prev_start = st;
        want_auto = au && !mn;
        want_man = mn && !au;
        nx = m_ph;
        dn = 0;
        if (es) begin
            nx = P_FAULT;
        end else if (m_ph == P_IDLE) begin
            if (!sp && edge_s && want_auto) nx = P_SPINUP;
            else if (!sp && edge_s && want_man) nx = P_MANUAL;
        end else if (m_ph == P_SPINUP || m_ph == P_RUN) begin
            if (sp || !want_auto) begin
                nx = P_COAST;
            end else if (m_left == 1) begin
                nx = (m_ph == P_SPINUP) ? P_RUN : P_COAST;
                if (m_ph == P_RUN) m_flag = 1;
            end
        end else if (m_ph == P_MANUAL) begin
            if (sp || !want_man) nx = P_COAST;
        end else if (m_ph == P_COAST) begin
            if (m_left == 1) begin
                nx = P_IDLE;
                dn = m_flag;
            end
        end else if (m_ph == P_FAULT) begin
            if (sp) nx = P_IDLE;
        end
        if (nx != m_ph) m_left = dur(nx);
        else m_left = m_left - 1;
        if (nx == P_IDLE) m_flag = 0;
        m_ph = nx;
        sp_o = (nx == P_SPINUP || nx == P_RUN || nx == P_MANUAL);
        cl_o = sp_o || (nx == P_COAST);
        fd_o = (nx == P_RUN) || (nx == P_MANUAL && jg);
        return {3'(nx), sp_o, fd_o, cl_o, (nx != P_IDLE), (nx == P_FAULT), dn};
    endfunction

    task automatic step(input bit st, input bit sp, input bit es,
                        input bit au, input bit mn, input bit jg);
        @(negedge clk);
        rst_n = 1'b1;
        start = st; stop = sp; estop = es;
        auto_mode = au; man_mode = mn; jog = jg;
        exp_q.push_back(model_step(st, sp, es, au, mn, jg));
    endtask

    task automatic run(input int n, input bit st, input bit sp, input bit es,
                       input bit au, input bit mn, input bit jg);
        for (int i = 0; i < n; i++) step(st, sp, es, au, mn, jg);
    endtask

    // Reset is asserted between edges; outputs must drop before the next edge.
    task automatic do_reset(input int n);
        vec_t a;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        a = {state_o, spindle_on, feed_on, coolant_on, busy, fault, cycle_done};
        vectors++;
        if (a !== 9'd0) begin
            miscompares++;
            $display("FAIL async_reset @%0t: got %b required %b", $time, a, 9'd0);
        end
        model_reset();
        exp_q.push_back(9'd0);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            exp_q.push_back(9'd0);
        end
    endtask

    initial begin : monitor
        vec_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {state_o, spindle_on, feed_on, coolant_on, busy, fault, cycle_done};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got state=%0d sp/fd/cl/busy/flt/done=%b required state=%0d sp/fd/cl/busy/flt/done=%b",
                             $time, a[8:6], a[5:0], e[8:6], e[5:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit r_start, r_au, r_mn;
        int r_mode;
        do_reset(2);

        // Full AUTO cycle.
        run(2, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        run(20, 0, 0, 0, 1, 0, 0);

        // Stop during RUN cycle 3.
        step(1, 0, 0, 1, 0, 0);
        run(S + 2, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        run(6, 0, 0, 0, 1, 0, 0);

        // Estop during SPINUP, start ignored in FAULT, stop clears it.
        step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        run(3, 0, 0, 0, 1, 0, 0);

        // MAN mode jog, then switch to AUTO.
        run(2, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        run(3, 0, 0, 0, 0, 1, 1);
        run(2, 0, 0, 0, 0, 1, 0);
        run(6, 0, 0, 0, 1, 0, 0);

        // Boundaries: start+stop in IDLE, both mode bits, start held high.
        step(1, 1, 0, 1, 0, 0);
        run(3, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0);
        run(3, 0, 0, 0, 1, 1, 0);
        run(S + R + C + 8, 1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Reset mid-RUN.
        step(1, 0, 0, 1, 0, 0);
        run(S + 3, 0, 0, 0, 1, 0, 0);
        do_reset(2);
        run(3, 0, 0, 0, 1, 0, 0);

        // Randomised operator activity.
        r_start = 0; r_au = 1; r_mn = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) < 12) r_start = !r_start;
            if ($urandom_range(0, 99) < 3) begin
                r_mode = $urandom_range(0, 5);
                r_au = (r_mode == 0 || r_mode == 2 || r_mode == 4);
                r_mn = (r_mode == 1 || r_mode == 3 || r_mode == 4);
            end
            if ($urandom_range(0, 999) < 3) begin
                do_reset(1);
            end else begin
                step(r_start, ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 2),
                     r_au, r_mn, 1'($urandom_range(0, 1)));
            end
        end

        @(negedge clk);
        @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending entries required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lathe_cycle_sequencer.md
# lathe_cycle_sequencer

Sequencer for the lathe retrofit controller. It drives the spindle, feed and coolant outputs through a fixed timed machining cycle in AUTO mode, and through an operator-held jog cycle in MAN mode. It arbitrates between the start, stop and estop operator inputs and the mode selector. It replaces the free-running start/stop latch and on-delay timer with one explicit state machine that owns all actuator outputs.

## Interface
- `SPINUP_CYCLES`, default 16: spindle/coolant-only dwell before feed engages (≥1)
- `RUN_CYCLES`, default 64: feed-engaged cut duration in AUTO (≥1)
- `COAST_CYCLES`, default 16: feed and spindle off, coolant on, before IDLE (≥1)
- `TW`, default 16: timer width; every `*_CYCLES` must be ≤ 2^TW
- `clk` in 1: system clock
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: operator start, level; rising edge detected internally
- `stop` in 1: operator stop, level
- `estop` in 1: emergency stop, level, highest priority
- `auto_mode` in 1: AUTO selector
- `man_mode` in 1: MAN selector
- `jog` in 1: manual feed request, honoured only in MANUAL
- `spindle_on` out 1: spindle contactor
- `feed_on` out 1: feed drive enable
- `coolant_on` out 1: coolant pump
- `busy` out 1: high in any state other than IDLE
- `fault` out 1: high in FAULT
- `cycle_done` out 1: one-cycle pulse when a complete AUTO cycle returns to IDLE
- `state_o` out 3: current state encoding

## Operation
- All inputs are synchronous to `clk`; external synchronizers sit upstream.
- Mode is valid only when exactly one of `auto_mode`/`man_mode` is 1.
- States and actions:
  - IDLE: all outputs off.
  - SPINUP: spindle + coolant.
  - RUN: spindle + coolant + feed.
  - MANUAL: spindle + coolant, and `feed_on` = `jog` registered.
  - COAST: coolant only.
  - FAULT: all off, `fault`=1.
- Transition priority, highest first:
  1. `estop`=1 in any state → FAULT.
  2. `stop`=1 → COAST from SPINUP/RUN/MANUAL; IDLE stays IDLE even with a simultaneous start edge.
  3. Invalid mode while in SPINUP/RUN/MANUAL → COAST.
  4. Timer expiry.
  5. Start edge.
- IDLE + start edge + AUTO → SPINUP; IDLE + start edge + MAN → MANUAL; start edge with invalid mode is ignored.
- Timer-driven transitions: SPINUP expiry → RUN; RUN expiry → COAST with the completed flag set; COAST expiry → IDLE, pulsing `cycle_done` only if the flag is set. The flag clears on entry to IDLE.
- A start edge in any non-IDLE state is ignored. A mode change from MAN to AUTO in MANUAL counts as a mode change → COAST, not a restart.
- FAULT → IDLE only when `estop`=0 and `stop`=1 in the same cycle. `start` is ignored in FAULT.
- Timer: TW-bit down-counter, loaded with N−1 on state entry, expiry at 0, so every timed state lasts exactly N cycles. MANUAL, IDLE and FAULT do not use the timer.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE, all outputs 0, timer 0, completed flag 0, start-edge register 0. Reset mid-cycle kills the outputs immediately without a coast phase.
- All outputs are registered and change on the same edge as the state register. There is no combinational input-to-output path.
- Start edge: if `start`=0 at edge k−1 and `start`=1 at edge k, the state and outputs change at edge k (1-cycle latency).
- `start` held high across return to IDLE does not retrigger; a fresh rising edge is required.
- `estop`/`stop` act at the first edge at which they are sampled high; outputs are off (or coolant-only) from that edge.
- Full AUTO cycle: `busy` high for SPINUP_CYCLES+RUN_CYCLES+COAST_CYCLES cycles. `cycle_done` is high for the single cycle after the COAST→IDLE edge.
- In MANUAL, `feed_on` follows `jog` with 1-cycle latency.

## Structure
- Package `lathe_seq_pkg`:
  - State encoding localparams: IDLE=0, SPINUP=1, RUN=2, MANUAL=3, COAST=4, FAULT=5.
  - Output-bundle bit positions.
- Sub-module `seq_timer`: loadable TW-bit down-counter with `load`, `load_val` and `expired` ports. It is instantiated once.
- FSM, edge detect and output registers live in the top block.

## Test plan
All scenarios use S=4, R=8, C=3.
- Reset, then AUTO with a start pulse: spindle/coolant from the edge, feed on after 4 cycles for 8 cycles, coolant-only for 3 cycles, then IDLE; `cycle_done` pulses once; `busy` is high for 15 cycles.
- `stop` asserted during RUN cycle 3 → COAST next edge with feed and spindle off, coolant for 3 cycles, then IDLE with no `cycle_done`.
- `estop` during SPINUP → all outputs 0 and `fault`=1 at the next edge. Start pulses are ignored. `stop`=1 with `estop`=0 → IDLE.
- MAN mode, start edge, then jog toggled 0→1→0 → `feed_on` mirrors jog delayed 1 cycle. Switching to AUTO → COAST for 3 cycles, then IDLE.
- Boundary cases:
  - start+stop in the same cycle in IDLE → stays IDLE.
  - Start with both mode bits 1 → ignored.
  - Start held high through a full cycle → no second cycle.
  - `rst_n` low mid-RUN → all outputs 0 asynchronously.
